// File: rtl/execute_stage.sv
// MIPS32 EX stage: MEM/WB forwarding, ALU decode/execute and EX/MEM register.
// Optional macro BRANCH_TARGET_EN adds the registered branch_target_out port.
module execute_stage (
  input  logic        CLK,
  input  logic        RST,
  input  logic        branch,
  input  logic        jump,
  input  logic        AluSrc,
  input  logic [5:0]  opcode,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        RegWrite,
  input  logic        RegDst,
  input  logic        MemtoReg,
  input  logic [31:0] npc,
  input  logic [31:0] readdata1,
  input  logic [31:0] readdata2,
  input  logic [31:0] sigext,
  input  logic [4:0]  instruction_2521,
  input  logic [4:0]  instruction_2016,
  input  logic [4:0]  instruction_1511,
  input  logic [4:0]  MEMRegRd_wire,
  input  logic [4:0]  WBRegRd_wire,
  input  logic        MEM_RegWrite_wire,
  input  logic        WB_RegWrite_wire,
  input  logic [31:0] regExMem,
  input  logic [31:0] regMemWb,
  output logic        branch_out,
  output logic        jump_out,
  output logic        MemRead_out,
  output logic        MemWrite_out,
  output logic        MemtoReg_out,
  output logic        RegWrite_out,
  output logic [31:0] alu_out,
  output logic [31:0] readdata2_out,
  output logic [4:0]  muxRegDst_out
`ifdef BRANCH_TARGET_EN
  ,
  output logic [31:0] branch_target_out
`endif
);

  localparam int DATA_W = 32;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0A;
  localparam logic [5:0] OP_SLTIU = 6'h0B;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL  = 6'h00;
  localparam logic [5:0] FN_SRL  = 6'h02;
  localparam logic [5:0] FN_SRA  = 6'h03;
  localparam logic [5:0] FN_ADDU = 6'h21;
  localparam logic [5:0] FN_SUBU = 6'h23;
  localparam logic [5:0] FN_AND  = 6'h24;
  localparam logic [5:0] FN_OR   = 6'h25;
  localparam logic [5:0] FN_XOR  = 6'h26;
  localparam logic [5:0] FN_NOR  = 6'h27;
  localparam logic [5:0] FN_SLT  = 6'h2A;
  localparam logic [5:0] FN_SLTU = 6'h2B;

  // The MEM result is younger than the WB result, so it wins a double match.
  function automatic logic [DATA_W-1:0] fwd_sel(input logic [4:0]        idx,
                                                input logic [DATA_W-1:0] rf_val,
                                                input logic              mem_we,
                                                input logic [4:0]        mem_rd,
                                                input logic [DATA_W-1:0] mem_val,
                                                input logic              wb_we,
                                                input logic [4:0]        wb_rd,
                                                input logic [DATA_W-1:0] wb_val);
    if (mem_we && (mem_rd != 5'd0) && (mem_rd == idx))
      return mem_val;
    else if (wb_we && (wb_rd != 5'd0) && (wb_rd == idx))
      return wb_val;
    else
      return rf_val;
  endfunction

  function automatic logic [DATA_W-1:0] flag(input logic cond);
    return cond ? {{(DATA_W-1){1'b0}}, 1'b1} : '0;
  endfunction

  logic        [DATA_W-1:0] op_a_p0;
  logic        [DATA_W-1:0] fwd_b_p0;
  logic        [DATA_W-1:0] imm_p0;
  logic        [DATA_W-1:0] op_b_p0;
  logic signed [DATA_W-1:0] op_a_s_p0;
  logic signed [DATA_W-1:0] op_b_s_p0;
  logic        [5:0]        funct_p0;
  logic        [4:0]        shamt_p0;
  logic        [DATA_W-1:0] alu_res_p0;
  logic        [4:0]        dst_p0;

  assign op_a_p0  = fwd_sel(instruction_2521, readdata1, MEM_RegWrite_wire, MEMRegRd_wire,
                            regExMem, WB_RegWrite_wire, WBRegRd_wire, regMemWb);
  assign fwd_b_p0 = fwd_sel(instruction_2016, readdata2, MEM_RegWrite_wire, MEMRegRd_wire,
                            regExMem, WB_RegWrite_wire, WBRegRd_wire, regMemWb);

  // Logical immediates are zero-extended rather than sign-extended.
  assign imm_p0    = ((opcode == OP_ANDI) || (opcode == OP_ORI) || (opcode == OP_XORI)) ?
                     {16'b0, sigext[15:0]} : sigext;
  assign op_b_p0   = AluSrc ? imm_p0 : fwd_b_p0;
  assign op_a_s_p0 = op_a_p0;
  assign op_b_s_p0 = op_b_p0;
  assign funct_p0  = sigext[5:0];
  assign shamt_p0  = sigext[10:6];
  assign dst_p0    = RegDst ? instruction_1511 : instruction_2016;

  always_comb begin
    alu_res_p0 = '0;
    case (opcode)
      OP_RTYPE: begin
        case (funct_p0)
          FN_ADDU: alu_res_p0 = op_a_p0 + op_b_p0;
          FN_SUBU: alu_res_p0 = op_a_p0 - op_b_p0;
          FN_AND:  alu_res_p0 = op_a_p0 & op_b_p0;
          FN_OR:   alu_res_p0 = op_a_p0 | op_b_p0;
          FN_XOR:  alu_res_p0 = op_a_p0 ^ op_b_p0;
          FN_NOR:  alu_res_p0 = ~(op_a_p0 | op_b_p0);
          FN_SLT:  alu_res_p0 = flag(op_a_s_p0 < op_b_s_p0);
          FN_SLTU: alu_res_p0 = flag(op_a_p0 < op_b_p0);
          FN_SLL:  alu_res_p0 = op_b_p0 << shamt_p0;
          FN_SRL:  alu_res_p0 = op_b_p0 >> shamt_p0;
          FN_SRA:  alu_res_p0 = op_b_s_p0 >>> shamt_p0;
          default: alu_res_p0 = '0;
        endcase
      end
      OP_ADDIU, OP_LW, OP_SW: alu_res_p0 = op_a_p0 + op_b_p0;
      OP_SLTI:  alu_res_p0 = flag(op_a_s_p0 < op_b_s_p0);
      OP_SLTIU: alu_res_p0 = flag(op_a_p0 < op_b_p0);
      OP_ANDI:  alu_res_p0 = op_a_p0 & op_b_p0;
      OP_ORI:   alu_res_p0 = op_a_p0 | op_b_p0;
      OP_XORI:  alu_res_p0 = op_a_p0 ^ op_b_p0;
      OP_LUI:   alu_res_p0 = {sigext[15:0], 16'b0};
      OP_BEQ:   alu_res_p0 = flag(op_a_p0 == op_b_p0);
      OP_BNE:   alu_res_p0 = flag(op_a_p0 != op_b_p0);
      default:  alu_res_p0 = '0;
    endcase
  end

  // ---- p0 -> EX/MEM register ----
  always_ff @(posedge CLK) begin
    if (RST) begin
      branch_out    <= 1'b0;
      jump_out      <= 1'b0;
      MemRead_out   <= 1'b0;
      MemWrite_out  <= 1'b0;
      MemtoReg_out  <= 1'b0;
      RegWrite_out  <= 1'b0;
      alu_out       <= '0;
      readdata2_out <= '0;
      muxRegDst_out <= '0;
    end else begin
      branch_out    <= branch;
      jump_out      <= jump;
      MemRead_out   <= MemRead;
      MemWrite_out  <= MemWrite;
      MemtoReg_out  <= MemtoReg;
      RegWrite_out  <= RegWrite;
      alu_out       <= alu_res_p0;
      readdata2_out <= fwd_b_p0;
      muxRegDst_out <= dst_p0;
    end
  end

`ifdef BRANCH_TARGET_EN
  always_ff @(posedge CLK) begin
    if (RST) branch_target_out <= '0;
    else     branch_target_out <= npc + (sigext << 2);
  end
`else
  logic unused_npc;
  assign unused_npc = ^npc;
`endif

endmodule

// File: tb/tb_execute_stage.sv
// Randomized and directed bench for execute_stage against a behavioural EX-stage model.
module tb_execute_stage;

  logic        CLK = 1'b0;
  logic        RST;
  logic        branch, jump, AluSrc, MemRead, MemWrite, RegWrite, RegDst, MemtoReg;
  logic [5:0]  opcode;
  logic [31:0] npc, readdata1, readdata2, sigext, regExMem, regMemWb;
  logic [4:0]  instruction_2521, instruction_2016, instruction_1511;
  logic [4:0]  MEMRegRd_wire, WBRegRd_wire;
  logic        MEM_RegWrite_wire, WB_RegWrite_wire;
  logic        branch_out, jump_out, MemRead_out, MemWrite_out, MemtoReg_out, RegWrite_out;
  logic [31:0] alu_out, readdata2_out;
  logic [4:0]  muxRegDst_out;
`ifdef BRANCH_TARGET_EN
  logic [31:0] branch_target_out;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 CLK = ~CLK;

  execute_stage dut (
    .CLK(CLK), .RST(RST), .branch(branch), .jump(jump), .AluSrc(AluSrc), .opcode(opcode),
    .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .npc(npc), .readdata1(readdata1), .readdata2(readdata2),
    .sigext(sigext), .instruction_2521(instruction_2521), .instruction_2016(instruction_2016),
    .instruction_1511(instruction_1511), .MEMRegRd_wire(MEMRegRd_wire),
    .WBRegRd_wire(WBRegRd_wire), .MEM_RegWrite_wire(MEM_RegWrite_wire),
    .WB_RegWrite_wire(WB_RegWrite_wire), .regExMem(regExMem), .regMemWb(regMemWb),
    .branch_out(branch_out), .jump_out(jump_out), .MemRead_out(MemRead_out),
    .MemWrite_out(MemWrite_out), .MemtoReg_out(MemtoReg_out), .RegWrite_out(RegWrite_out),
    .alu_out(alu_out), .readdata2_out(readdata2_out), .muxRegDst_out(muxRegDst_out)
`ifdef BRANCH_TARGET_EN
    , .branch_target_out(branch_target_out)
`endif
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] req);
    n_checks++;
    if (got !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", name, got, req, $time);
    end
  endtask

  // Behavioural model: value an instruction's source register sees after bypassing.
  function automatic logic [31:0] src_value(input logic [4:0] r, input logic [31:0] rf);
    if (MEM_RegWrite_wire && MEMRegRd_wire == r && r != 0) return regExMem;
    if (WB_RegWrite_wire && WBRegRd_wire == r && r != 0)   return regMemWb;
    return rf;
  endfunction

  function automatic logic [31:0] model_result(input logic [31:0] a, input logic [31:0] rtv);
    logic [31:0] b;
    int unsigned sh;
    b  = rtv;
    if (AluSrc) b = (opcode inside {6'h0C, 6'h0D, 6'h0E}) ? (sigext & 32'h0000FFFF) : sigext;
    sh = sigext[10:6];
    if (opcode == 6'h00) begin
      case (sigext[5:0])
        6'h21: return a + b;
        6'h23: return a - b;
        6'h24: return a & b;
        6'h25: return a | b;
        6'h26: return a ^ b;
        6'h27: return ~(a | b);
        6'h2A: return ($signed(a) < $signed(b)) ? 1 : 0;
        6'h2B: return (a < b) ? 1 : 0;
        6'h00: return b << sh;
        6'h02: return b >> sh;
        6'h03: return $unsigned($signed(b) >>> sh);
        default: return 0;
      endcase
    end
    case (opcode)
      6'h09, 6'h23, 6'h2B: return a + b;
      6'h0A: return ($signed(a) < $signed(b)) ? 1 : 0;
      6'h0B: return (a < b) ? 1 : 0;
      6'h0C: return a & b;
      6'h0D: return a | b;
      6'h0E: return a ^ b;
      6'h0F: return sigext * 32'h10000;
      6'h04: return (a == b) ? 1 : 0;
      6'h05: return (a != b) ? 1 : 0;
      default: return 0;
    endcase
  endfunction

  logic        exp_vld = 1'b0;
  logic [31:0] e_alu, e_rd2, e_bt;
  logic [4:0]  e_dst;
  logic [5:0]  e_ctrl;

  always @(posedge CLK) begin
    if (RST) begin
      e_alu = 0; e_rd2 = 0; e_dst = 0; e_ctrl = 0; e_bt = 0;
    end else begin
      e_rd2  = src_value(instruction_2016, readdata2);
      e_alu  = model_result(src_value(instruction_2521, readdata1), e_rd2);
      e_dst  = RegDst ? instruction_1511 : instruction_2016;
      e_ctrl = {branch, jump, MemRead, MemWrite, MemtoReg, RegWrite};
      e_bt   = npc + sigext * 4;
    end
    exp_vld = 1'b1;
  end

  always @(negedge CLK) begin
    if (exp_vld) begin
      chk("model_alu", alu_out, e_alu);
      chk("model_rd2", readdata2_out, e_rd2);
      chk("model_dst", {27'b0, muxRegDst_out}, {27'b0, e_dst});
      chk("model_ctrl", {26'b0, branch_out, jump_out, MemRead_out, MemWrite_out,
                         MemtoReg_out, RegWrite_out}, {26'b0, e_ctrl});
`ifdef BRANCH_TARGET_EN
      chk("model_bt", branch_target_out, e_bt);
`endif
    end
  end

  task automatic clear_inputs();
    RST = 0; branch = 0; jump = 0; AluSrc = 0; opcode = 0; MemRead = 0; MemWrite = 0;
    RegWrite = 0; RegDst = 0; MemtoReg = 0; npc = 0; readdata1 = 0; readdata2 = 0;
    sigext = 0; instruction_2521 = 0; instruction_2016 = 0; instruction_1511 = 0;
    MEMRegRd_wire = 0; WBRegRd_wire = 0; MEM_RegWrite_wire = 0; WB_RegWrite_wire = 0;
    regExMem = 0; regMemWb = 0;
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b);
    clear_inputs();
    instruction_2521 = 5'd1; instruction_2016 = 5'd2;
    readdata1 = a; readdata2 = b; sigext = {26'b0, fn};
    step();
  endtask

  logic [5:0] op_tab [12] = '{6'h00, 6'h04, 6'h05, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D,
                              6'h0E, 6'h0F, 6'h23, 6'h2B};
  logic [5:0] fn_tab [11] = '{6'h21, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A, 6'h2B,
                              6'h00, 6'h02, 6'h03};

  initial begin
    clear_inputs();
    // Reset with busy inputs: everything must read zero.
    RST = 1; readdata1 = 32'hDEAD; readdata2 = 32'hBEEF; sigext = 32'h21; RegDst = 1;
    instruction_1511 = 5'd9; branch = 1; RegWrite = 1; npc = 32'h100;
    step(); step();
    chk("rst_alu", alu_out, 0);
    chk("rst_rd2", readdata2_out, 0);
    chk("rst_dst", {27'b0, muxRegDst_out}, 0);
    chk("rst_ctrl", {26'b0, branch_out, jump_out, MemRead_out, MemWrite_out,
                     MemtoReg_out, RegWrite_out}, 0);

    rtype(6'h21, 32'd5, 32'hFFFFFFFE);
    chk("addu_5_m2", alu_out, 32'h3);

    clear_inputs(); opcode = 6'h0D; AluSrc = 1; sigext = 1; readdata1 = 0; step();
    chk("ori", alu_out, 1);
    clear_inputs(); opcode = 6'h09; AluSrc = 1; sigext = 2; readdata1 = 3; step();
    chk("addiu", alu_out, 5);
    clear_inputs(); opcode = 6'h0D; AluSrc = 1; sigext = 32'hFFFF8000; step();
    chk("ori_zext", alu_out, 32'h00008000);

    rtype(6'h25, 1, 0);
    chk("or", alu_out, 1);
    clear_inputs(); opcode = 6'h04; readdata1 = 1; readdata2 = 0; step();
    chk("beq", alu_out, 0);
    clear_inputs(); opcode = 6'h05; readdata1 = 1; readdata2 = 0; step();
    chk("bne", alu_out, 1);
    rtype(6'h2A, 32'hFFFFFFFF, 1);
    chk("slt_neg", alu_out, 1);
    rtype(6'h2B, 32'hFFFFFFFF, 1);
    chk("sltu_big", alu_out, 0);
    clear_inputs(); sigext = {21'b0, 5'd4, 6'h03}; readdata2 = 32'h80000000; step();
    chk("sra", alu_out, 32'hF8000000);
    rtype(6'h3F, 7, 9);
    chk("bad_funct", alu_out, 0);

    // Forwarding on rs=3 with both later stages targeting r3.
    clear_inputs(); sigext = 32'h21; instruction_2521 = 3; instruction_2016 = 8;
    readdata1 = 100; readdata2 = 1; MEM_RegWrite_wire = 1; MEMRegRd_wire = 3;
    regExMem = 10; WB_RegWrite_wire = 1; WBRegRd_wire = 3; regMemWb = 20; step();
    chk("fwd_mem_wins", alu_out, 11);
    MEM_RegWrite_wire = 0; step();
    chk("fwd_wb", alu_out, 21);
    MEM_RegWrite_wire = 1; MEMRegRd_wire = 0; WB_RegWrite_wire = 0; step();
    chk("fwd_none", alu_out, 101);
    instruction_2016 = 3; MEMRegRd_wire = 3; step();
    chk("fwd_rt_store", readdata2_out, 10);

    clear_inputs(); RegDst = 1; instruction_1511 = 7; instruction_2016 = 4; MemWrite = 1; step();
    chk("regdst_rd", {27'b0, muxRegDst_out}, 7);
    chk("ctrl_delay", {31'b0, MemWrite_out}, 1);
    RegDst = 0; MemWrite = 0; step();
    chk("regdst_rt", {27'b0, muxRegDst_out}, 4);
    chk("ctrl_clear", {31'b0, MemWrite_out}, 0);

    rtype(6'h21, 40, 2);
    RST = 1; step();
    chk("rst_mid", alu_out, 0);
    RST = 0; step();
    chk("resume", alu_out, 42);

    for (int i = 0; i < 3000; i++) begin
      RST = ($urandom_range(0, 60) == 0);
      {branch, jump, MemRead, MemWrite, RegWrite, RegDst, MemtoReg, AluSrc} = 8'($urandom);
      opcode = ($urandom_range(0, 9) == 0) ? 6'($urandom) : op_tab[$urandom_range(0, 11)];
      sigext = $urandom;
      if ($urandom_range(0, 1) == 0) sigext = {{16{sigext[15]}}, sigext[15:0]};
      if (opcode == 6'h00 && $urandom_range(0, 7) != 0)
        sigext[5:0] = fn_tab[$urandom_range(0, 10)];
      readdata1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
      readdata2 = ($urandom_range(0, 3) == 0) ? readdata1 : $urandom;
      npc = $urandom; regExMem = $urandom; regMemWb = $urandom;
      instruction_2521 = 5'($urandom_range(0, 3)); instruction_2016 = 5'($urandom_range(0, 3));
      instruction_1511 = 5'($urandom);
      MEMRegRd_wire = 5'($urandom_range(0, 3)); WBRegRd_wire = 5'($urandom_range(0, 3));
      MEM_RegWrite_wire = 1'($urandom); WB_RegWrite_wire = 1'($urandom);
      step();
    end

    clear_inputs();
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 5-stage MIPS32 pipeline, sitting between the ID/EX and MEM stages.
- Resolves operand forwarding from the MEM and WB stages.
- Decodes ALU control from opcode and funct, then performs the ALU operation and selects the destination register.
- Latches all results and pass-through control bits into the EX/MEM pipeline register.

Parameters:
- none. Datapath is fixed at 32 bits; register index is fixed at 5 bits.

Ports:
CLK  in  1  clock, rising-edge
RST  in  1  synchronous active-high reset
branch  in  1  branch control (passed through)
jump  in  1  jump control (passed through)
AluSrc  in  1  1 = operand B is sigext, 0 = operand B is the forwarded rt value
opcode  in  6  instruction opcode [31:26]
MemRead  in  1  memory read control (passed through)
MemWrite  in  1  memory write control (passed through)
RegWrite  in  1  register write control (passed through)
RegDst  in  1  1 = destination is rd, 0 = destination is rt
MemtoReg  in  1  writeback source select (passed through)
npc  in  32  PC+4 of the instruction
readdata1  in  32  register-file rs value
readdata2  in  32  register-file rt value
sigext  in  32  sign-extended immediate; bits [5:0]=funct, [10:6]=shamt
instruction_2521  in  5  rs
instruction_2016  in  5  rt
instruction_1511  in  5  rd
MEMRegRd_wire  in  5  destination register of the instruction in MEM
WBRegRd_wire  in  5  destination register of the instruction in WB
MEM_RegWrite_wire  in  1  MEM-stage write enable
WB_RegWrite_wire  in  1  WB-stage write enable
regExMem  in  32  ALU result held in EX/MEM
regMemWb  in  32  writeback value held in MEM/WB
branch_out, jump_out, MemRead_out, MemWrite_out, MemtoReg_out, RegWrite_out  out  1 each  registered control bits
alu_out  out  32  registered ALU result
readdata2_out  out  32  registered forwarded rt value (store data)
muxRegDst_out  out  5  registered destination register

Behaviour:
- All outputs are registered; latency is exactly 1 cycle, with no stall or enable input.
- RST sampled high at a rising edge clears every output to 0.
- Operand A forwarding:
  - If MEM_RegWrite_wire=1, MEMRegRd_wire≠0 and MEMRegRd_wire=rs, A = regExMem.
  - Else if WB_RegWrite_wire=1, WBRegRd_wire≠0 and WBRegRd_wire=rs, A = regMemWb.
  - Else A = readdata1.
  - MEM has priority over WB when both match.
- Forwarded rt value (fwdB) uses the same forwarding rules with rt. readdata2_out = fwdB.
- Operand B = AluSrc ? imm : fwdB.
  - imm = {16'b0, sigext[15:0]} for ANDI, ORI and XORI.
  - imm = sigext for all other opcodes.
- opcode 0x00 (RTYPE), selected by funct = sigext[5:0]:
  - 0x21 ADDU: A+B.
  - 0x23 SUBU: A−B.
  - 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR.
  - 0x2A SLT: signed less-than, result 1/0.
  - 0x2B SLTU: unsigned less-than, result 1/0.
  - 0x00 SLL, 0x02 SRL, 0x03 SRA: shift B by sigext[10:6].
  - Any other funct gives result 0.
- I-type opcodes:
  - ADDIU 0x09: A+B.
  - SLTI 0x0A: signed less-than.
  - SLTIU 0x0B: unsigned less-than.
  - ANDI 0x0C, ORI 0x0D, XORI 0x0E: bitwise.
  - LUI 0x0F: {sigext[15:0],16'b0}.
  - LW 0x23 and SW 0x2B: A+B (address).
- Branch opcodes produce a condition flag, not a subtraction:
  - BEQ 0x04: alu_out = (A==B) ? 1 : 0.
  - BNE 0x05: alu_out = (A!=B) ? 1 : 0.
- Any unlisted opcode: alu_out = 0.
- All addition and subtraction wraps modulo 2^32; no overflow trap.
- muxRegDst_out = RegDst ? rd : rt.
- Control bits pass through unchanged, one cycle delayed.

Optional Feature:
- Macro BRANCH_TARGET_EN.
- Defined: adds output branch_target_out [31:0], registered, = npc + (sigext<<2), cleared by RST.
- Undefined: the port does not exist and npc is unused.

Test Plan:
- RTYPE, sigext funct 0x21, readdata1=5, readdata2=−2, no forwarding → next edge alu_out=0x00000003.
- ORI, AluSrc=1, sigext=1, readdata1=0 → alu_out=1. Then ADDIU, sigext=2, readdata1=3 → alu_out=5.
- RTYPE funct 0x25 with 1,0 → 1. BEQ with 1,0 → 0. BNE with 1,0 → 1.
- Forwarding, rs=3:
  - MEM_RegWrite_wire=1, MEMRegRd_wire=3, regExMem=10, WB also matching with regMemWb=20, ADDU with B=1 → alu_out=11 (MEM wins).
  - MEM_RegWrite_wire=0 → alu_out=21.
  - MEMRegRd_wire=0 → no forwarding.
- RegDst=1, rd=7, rt=4 → muxRegDst_out=7; RegDst=0 → 4. Control bits appear one cycle later.
- RST=1 at an edge with nonzero inputs → all outputs 0 at that edge; normal operation resumes the cycle after RST drops.
